// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq: multi-cycle packed-BCD ALU with a start/done handshake.
// BCD_ALU_SAT_EN makes the result saturate to all nines on overflow.
module bcd_alu_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                neg,
  output logic                ovf,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int SW = W + 4;
  localparam int CW = $clog2(DIGITS + BIN_W + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;

  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDSUB,
    S_BIN_CONV,
    S_LOGIC,
    S_DABBLE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_res;
  logic [2:0]       r_op;
  logic [BIN_W-1:0] r_bx;
  logic [BIN_W-1:0] r_by;
  logic [BIN_W-1:0] r_bin;
  logic [SW-1:0]    r_scr;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_neg;
  logic             r_ovf;
  logic             r_err;

  logic             w_bad;
  logic             w_last_d;
  logic             w_last_b;
  logic [4:0]       w_sum;
  logic [4:0]       w_dif;
  logic [3:0]       w_dig;
  logic             w_cout;
  logic [W-1:0]     w_acc_n;
  logic             w_add_ovf;
  logic [W-1:0]     w_add_res;
  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_scr_n;
  logic             w_dab_ovf;
  logic [W-1:0]     w_dab_res;
  logic [3:0]       w_xtop;
  logic [3:0]       w_ytop;

  function automatic logic f_bad(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  assign w_bad    = (op > OP_OR) | f_bad(a) | f_bad(b);
  assign w_last_d = (r_cnt == CW'(DIGITS - 1));
  assign w_last_b = (r_cnt == CW'(BIN_W - 1));
  assign w_xtop   = r_x[W-1 -: 4];
  assign w_ytop   = r_y[W-1 -: 4];

  // One BCD digit of add or subtract on the low digits of x and y.
  always_comb begin
    w_sum  = {1'b0, r_x[3:0]} + {1'b0, r_y[3:0]} + {4'd0, r_c};
    w_dif  = {1'b0, r_x[3:0]} - {1'b0, r_y[3:0]} - {4'd0, r_c};
    w_dig  = w_sum[3:0];
    w_cout = 1'b0;
    if (r_op == OP_SUB) begin
      if (w_dif[4]) begin
        w_dig  = w_dif[3:0] + 4'd10;
        w_cout = 1'b1;
      end else begin
        w_dig  = w_dif[3:0];
      end
    end else if (w_sum > 5'd9) begin
      w_dig  = w_sum[3:0] - 4'd10;
      w_cout = 1'b1;
    end
  end

  assign w_acc_n   = {w_dig, r_acc[W-1:4]};
  assign w_add_ovf = (r_op == OP_ADD) & w_cout;

  // Add-3 correction on every scratch digit before the next shift.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i <= DIGITS; i++)
      if (r_scr[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
  end

  assign w_scr_n   = (w_adj << 1)
                   | {{(SW-1){1'b0}}, r_bin[BIN_W-1]};
  assign w_dab_ovf = |w_scr_n[SW-1:W];

`ifdef BCD_ALU_SAT_EN
  assign w_add_res = w_add_ovf ? NINES : w_acc_n;
  assign w_dab_res = w_dab_ovf ? NINES : w_scr_n[W-1:0];
`else
  assign w_add_res = w_acc_n;
  assign w_dab_res = w_scr_n[W-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad)            w_next = S_DONE;
          else if (op <= OP_SUB) w_next = S_ADDSUB;
          else                  w_next = S_BIN_CONV;
        end
      end
      S_ADDSUB:   if (w_last_d) w_next = S_DONE;
      S_BIN_CONV: if (w_last_d) w_next = S_LOGIC;
      S_LOGIC:    w_next = S_DABBLE;
      S_DABBLE:   if (w_last_b) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Operand capture and the per-state datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_res <= '0;
      r_op  <= '0;
      r_bx  <= '0;
      r_by  <= '0;
      r_bin <= '0;
      r_scr <= '0;
      r_cnt <= '0;
      r_c   <= 1'b0;
      r_neg <= 1'b0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_neg <= 1'b0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
            r_c   <= 1'b0;
            r_acc <= '0;
            r_bx  <= '0;
            r_by  <= '0;
            r_scr <= '0;
            r_x   <= a;
            r_y   <= b;
            if (w_bad) begin
              r_err <= 1'b1;
              r_res <= '0;
            end else if (op == OP_SUB && a < b) begin
              r_x   <= b;
              r_y   <= a;
              r_neg <= 1'b1;
            end
          end
        end
        S_ADDSUB: begin
          r_x   <= r_x >> 4;
          r_y   <= r_y >> 4;
          r_c   <= w_cout;
          r_acc <= w_acc_n;
          r_cnt <= r_cnt + CW'(1);
          if (w_last_d) begin
            r_res <= w_add_res;
            r_ovf <= w_add_ovf;
          end
        end
        S_BIN_CONV: begin
          r_x   <= r_x << 4;
          r_y   <= r_y << 4;
          r_bx  <= r_bx * BIN_W'(10) + BIN_W'(w_xtop);
          r_by  <= r_by * BIN_W'(10) + BIN_W'(w_ytop);
          r_cnt <= w_last_d ? '0 : r_cnt + CW'(1);
        end
        S_LOGIC: begin
          r_cnt <= '0;
          unique case (r_op)
            OP_XOR:  r_bin <= r_bx ^ r_by;
            OP_AND:  r_bin <= r_bx & r_by;
            default: r_bin <= r_bx | r_by;
          endcase
        end
        S_DABBLE: begin
          r_scr <= w_scr_n;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last_b) begin
            r_res <= w_dab_res;
            r_ovf <= w_dab_ovf;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done   = (r_state == S_DONE);
  assign result = r_res;
  assign neg    = r_neg;
  assign ovf    = r_ovf;
  assign err    = r_err;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb_bcd_alu_seq: vector table, corner sequences and a
// decimal-arithmetic reference model for bcd_alu_seq.
module tb_bcd_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        neg;
  logic        ovf;
  logic        err;

  int n_pass = 0;
  int n_tot  = 0;

`ifdef BCD_ALU_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  bcd_alu_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .neg(neg), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        n;
    logic        o;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic logic bad_bcd(input logic [15:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int s;
    s = 0;
    for (int i = 3; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
    return s;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                       input logic [2:0] mop, output logic [15:0] res,
                       output logic n, output logic o,
                       output logic e, output int lat);
    int va, vb, v;
    va = bcd2int(ma);
    vb = bcd2int(mb);
    v = 0;
    n = 1'b0;
    o = 1'b0;
    e = (mop > 3'd4) || bad_bcd(ma) || bad_bcd(mb);
    res = 16'h0;
    lat = 1;
    if (!e) begin
      case (mop)
        3'd0: begin v = va + vb; lat = 5; end
        3'd1: begin
          lat = 5;
          if (va < vb) begin n = 1'b1; v = vb - va; end
          else v = va - vb;
        end
        3'd2: begin v = va ^ vb; lat = 20; end
        3'd3: begin v = va & vb; lat = 20; end
        default: begin v = va | vb; lat = 20; end
      endcase
      o = (v > 9999);
      res = int2bcd(v % 10000);
      if (o && SAT) res = 16'h9999;
    end
  endtask

  task automatic run_op(input string nm, input logic [15:0] ta,
                        input logic [15:0] tb, input logic [2:0] top,
                        input logic [15:0] er, input logic en,
                        input logic eo, input logic ee,
                        input int elat, input int poke);
    int n;
    logic bbad;
    logic extra;
    @(negedge clk);
    a = ta; b = tb; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
    n = 1;
    bbad = 1'b0;
    while (1) begin
      start = (poke != 0) && (n == poke);
      if (done || n >= 60) break;
      if (!busy) bbad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({nm, ".lat"}, n, elat);
    check({nm, ".res"}, result, er);
    check({nm, ".neg"}, neg, en);
    check({nm, ".ovf"}, ovf, eo);
    check({nm, ".err"}, err, ee);
    check({nm, ".busy"}, {busy, bbad}, 2'b00);
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, ".pulse"}, {done, busy}, 2'b00);
    if (poke != 0) begin
      extra = 1'b0;
      repeat (8) begin
        @(posedge clk); #1;
        if (done || busy) extra = 1'b1;
      end
      check({nm, ".noq"}, extra, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] ra, rb, rr;
    logic [2:0]  rop;
    logic        rn, ro, re;
    int          rl;
    logic        hit;

    tbl[0]  = '{16'h1234, 16'h5678, 3'd0, 16'h6912, 0, 0, 0, 5};
    tbl[1]  = '{16'h9999, 16'h0001, 3'd0,
                SAT ? 16'h9999 : 16'h0000, 0, 1, 0, 5};
    tbl[2]  = '{16'h0100, 16'h0250, 3'd1, 16'h0150, 1, 0, 0, 5};
    tbl[3]  = '{16'h0250, 16'h0250, 3'd1, 16'h0000, 0, 0, 0, 5};
    tbl[4]  = '{16'h1234, 16'h5678, 3'd2, 16'h4860, 0, 0, 0, 20};
    tbl[5]  = '{16'h9999, 16'h0240, 3'd4,
                SAT ? 16'h9999 : 16'h0239, 0, 1, 0, 20};
    tbl[6]  = '{16'h12A4, 16'h0000, 3'd0, 16'h0000, 0, 0, 1, 1};
    tbl[7]  = '{16'h1234, 16'h5678, 3'd6, 16'h0000, 0, 0, 1, 1};
    tbl[8]  = '{16'h9999, 16'h0240, 3'd3, 16'h0000, 0, 0, 0, 20};
    tbl[9]  = '{16'h9000, 16'h0001, 3'd1, 16'h8999, 0, 0, 0, 5};
    tbl[10] = '{16'h0001, 16'h9000, 3'd1, 16'h8999, 1, 0, 0, 5};
    tbl[11] = '{16'h5000, 16'h5000, 3'd0,
                SAT ? 16'h9999 : 16'h0000, 0, 1, 0, 5};
    tbl[12] = '{16'h0000, 16'h000F, 3'd0, 16'h0000, 0, 0, 1, 1};
    tbl[13] = '{16'h0001, 16'h0002, 3'd5, 16'h0000, 0, 0, 1, 1};
    tbl[14] = '{16'h0000, 16'h0000, 3'd4, 16'h0000, 0, 0, 0, 20};
    tbl[15] = '{16'h9999, 16'h9999, 3'd2, 16'h0000, 0, 0, 0, 20};

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {busy, done, result, neg, ovf, err}, 21'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
             tbl[i].res, tbl[i].n, tbl[i].o, tbl[i].e, tbl[i].lat, 0);

    run_op("pokeadd", 16'h1234, 16'h5678, 3'd0,
           16'h6912, 0, 0, 0, 5, 2);
    run_op("pokedone", 16'h1234, 16'h5678, 3'd2,
           16'h4860, 0, 0, 0, 20, 20);

    @(negedge clk);
    a = 16'h1234; b = 16'h5678; op = 3'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstdab", {busy, done, result, neg, ovf, err}, 21'h0);
    hit = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) hit = 1'b1;
    end
    check("rstdab.quiet", hit, 1'b0);
    run_op("afterrst", 16'h1234, 16'h5678, 3'd0,
           16'h6912, 0, 0, 0, 5, 0);

    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h0001; op = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    hit = busy;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) hit = 1'b1;
    end
    check("rstwins", hit, 1'b0);

    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < 4; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0)
        ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) < 8) rop = 3'($urandom_range(0, 4));
      else rop = 3'($urandom_range(5, 7));
      model(ra, rb, rop, rr, rn, ro, re, rl);
      run_op($sformatf("rnd%0d", k), ra, rb, rop, rr, rn, ro, re, rl, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
